// File: rtl/mmio_uart_ctrl_pkg.sv
// rtl/mmio_uart_ctrl_pkg.sv - shared constants for the MMIO UART controller
// Purpose: register offsets within the MMIO window, status bit indices and
// the default counter width. This package has no ports.
package mmio_uart_ctrl_pkg;

  localparam int CNT_WIDTH_DEF = 32;

  // Offsets are taken from addr[27:0] once the window nibble has matched.
  localparam logic [27:0] MMIO_STATUS  = 28'h000_0000;
  localparam logic [27:0] MMIO_RX      = 28'h000_0004;
  localparam logic [27:0] MMIO_TX      = 28'h000_0008;
  localparam logic [27:0] MMIO_CYC     = 28'h000_0010;
  localparam logic [27:0] MMIO_INST    = 28'h000_0014;
  localparam logic [27:0] MMIO_CNT_RST = 28'h000_0018;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_VALID = 1;

endpackage

// File: rtl/mmio_uart_ctrl_counter.sv
// rtl/mmio_uart_ctrl_counter.sv - free-running counter with clear and increment
// Module: mmio_counter.
// Ports:
//   clk_i  - core clock
//   rst_i  - synchronous active-high reset
//   clr_i  - synchronous clear, wins over inc_i
//   inc_i  - count enable
//   cnt_o  - current count, wraps modulo 2^WIDTH
module mmio_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - MEM-stage MMIO decoder for UART, cycle and instruction counters
// Optional build macro: MMIO_TX_BUF_EN (1-entry TX holding register).
// Ports:
//   clk_i, rst_i         - core clock, synchronous active-high reset
//   addr_i, wdata_i      - load/store address and unshifted store data
//   we_i, re_i           - store / load strobes (qualified here by the window decode)
//   inst_retire_i        - one instruction retires this cycle
//   uart_tx_ready_i      - UART data_in_ready
//   uart_tx_valid_o      - UART data_in_valid
//   uart_tx_data_o       - UART data_in
//   uart_rx_valid_i      - UART data_out_valid
//   uart_rx_data_i       - UART data_out
//   uart_rx_ready_o      - UART data_out_ready (one-cycle pop)
//   mmio_hit_o           - last cycle's load hit the window; selects rdata_o over dmem
//   rdata_o              - registered load data
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic        inst_retire_i,
  input  logic        uart_tx_ready_i,
  output logic        uart_tx_valid_o,
  output logic [7:0]  uart_tx_data_o,
  input  logic        uart_rx_valid_i,
  input  logic [7:0]  uart_rx_data_i,
  output logic        uart_rx_ready_o,
  output logic        mmio_hit_o,
  output logic [31:0] rdata_o
);

  logic                 hit;
  logic [27:0]          off;
  logic                 wr_hit;
  logic                 rd_hit;
  logic                 cnt_clr;
  logic                 tx_wr;
  logic                 rx_pop;
  logic                 tx_stat;
  logic [31:0]          rd_val;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] inst_cnt;

  logic                 tx_valid_q;
  logic [7:0]           tx_data_q;
  logic                 rx_ready_q;
  logic                 mmio_hit_q;
  logic [31:0]          rdata_q;

  logic                 unused_wdata;
  assign unused_wdata = ^wdata_i[31:8];

  assign hit     = (addr_i[31:28] == MMIO_BASE[31:28]);
  assign off     = addr_i[27:0];
  assign wr_hit  = we_i & hit;
  assign rd_hit  = re_i & hit;
  assign cnt_clr = wr_hit && (off == MMIO_CNT_RST);
  assign tx_wr   = wr_hit && (off == MMIO_TX);
  // A simultaneous store suppresses the load, so no byte is popped for it.
  assign rx_pop  = rd_hit && !we_i && (off == MMIO_RX) && uart_rx_valid_i;

`ifdef MMIO_TX_BUF_EN
  // Software sees "holding register free" rather than the raw UART ready.
  assign tx_stat = ~tx_valid_q;
`else
  assign tx_stat = uart_tx_ready_i;
`endif

  always_comb begin
    rd_val = '0;
    if (!we_i) begin
      case (off)
        MMIO_STATUS: begin
          rd_val[STAT_TX_READY] = tx_stat;
          rd_val[STAT_RX_VALID] = uart_rx_valid_i;
        end
        MMIO_RX:   rd_val = uart_rx_valid_i ? {24'b0, uart_rx_data_i} : 32'b0;
        MMIO_CYC:  rd_val = 32'(cycle_cnt);
        MMIO_INST: rd_val = 32'(inst_cnt);
        default:   rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      mmio_hit_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mmio_hit_q <= rd_hit;
      // Non-hit loads leave rdata untouched; the writeback mux ignores it anyway.
      if (rd_hit) begin
        rdata_q <= rd_val;
      end
      rx_ready_q <= rx_pop;
`ifdef MMIO_TX_BUF_EN
      if (tx_valid_q) begin
        if (uart_tx_ready_i) begin
          tx_valid_q <= 1'b0;
        end
      end else if (tx_wr) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= wdata_i[7:0];
      end
`else
      // Without buffering, a store while the UART is busy is simply lost.
      tx_valid_q <= tx_wr & uart_tx_ready_i;
      if (tx_wr && uart_tx_ready_i) begin
        tx_data_q <= wdata_i[7:0];
      end
`endif
    end
  end

  mmio_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (1'b1),
    .cnt_o (cycle_cnt)
  );

  mmio_counter #(.WIDTH(CNT_WIDTH)) u_inst_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (inst_retire_i),
    .cnt_o (inst_cnt)
  );

  assign uart_tx_valid_o = tx_valid_q;
  assign uart_tx_data_o  = tx_data_q;
  assign uart_rx_ready_o = rx_ready_q;
  assign mmio_hit_o      = mmio_hit_q;
  assign rdata_o         = rdata_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb/tb_mmio_uart_ctrl.sv - self-checking bench for mmio_uart_ctrl
module tb_mmio_uart_ctrl;

`ifdef MMIO_TX_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        inst_retire;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mmio_hit;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    logic        pop;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        rx_v;
    logic [7:0]  rx_d;
    logic        tx_r;
    logic [31:0] exp_rdata;
    logic        exp_pop;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  mmio_uart_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .we_i            (we),
    .re_i            (re),
    .inst_retire_i   (inst_retire),
    .uart_tx_ready_i (tx_ready),
    .uart_tx_valid_o (tx_valid),
    .uart_tx_data_o  (tx_data),
    .uart_rx_valid_i (rx_valid),
    .uart_rx_data_i  (rx_data),
    .uart_rx_ready_o (rx_ready),
    .mmio_hit_o      (mmio_hit),
    .rdata_o         (rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chk(input string name, input logic [31:0] a, input logic [31:0] exp_rd,
                          input logic exp_pop);
    exp_t e;
    addr = a;
    we   = 1'b0;
    re   = 1'b1;
    e.rdata = exp_rd;
    e.hit   = (a[31:28] == 4'h8);
    e.pop   = exp_pop;
    sb_q.push_back(e);
    tick();
    re = 1'b0;
    e = sb_q.pop_front();
    check({name, " rdata"}, rdata, e.rdata);
    check({name, " hit"}, 32'(mmio_hit), 32'(e.hit));
    check({name, " rx_ready"}, 32'(rx_ready), 32'(e.pop));
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] pat;

    vecs[0] = '{32'h8000_0000, 1'b1, 8'h5A, 1'b0, BUF ? 32'h3 : 32'h2, 1'b0};
    vecs[1] = '{32'h8000_0000, 1'b0, 8'h00, 1'b1, 32'h1,  1'b0};
    vecs[2] = '{32'h8000_0004, 1'b1, 8'h5A, 1'b1, 32'h5A, 1'b1};
    vecs[3] = '{32'h8000_0004, 1'b0, 8'h5A, 1'b1, 32'h0,  1'b0};
    vecs[4] = '{32'h8000_0004, 1'b1, 8'hA5, 1'b1, 32'hA5, 1'b1};
    vecs[5] = '{32'h1000_0004, 1'b1, 8'h77, 1'b1, 32'hA5, 1'b0};
    vecs[6] = '{32'h8000_0008, 1'b1, 8'h77, 1'b1, 32'h0,  1'b0};
    vecs[7] = '{32'h8000_000C, 1'b1, 8'h77, 1'b1, 32'h0,  1'b0};
    vecs[8] = '{32'h8000_001C, 1'b1, 8'h77, 1'b1, 32'h0,  1'b0};
    vecs[9] = '{32'h8FFF_FFF0, 1'b1, 8'h77, 1'b1, 32'h0,  1'b0};

    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    inst_retire = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) tick();
    check("reset tx_valid", 32'(tx_valid), 32'h0);
    check("reset tx_data", 32'(tx_data), 32'h0);
    check("reset rx_ready", 32'(rx_ready), 32'h0);
    check("reset mmio_hit", 32'(mmio_hit), 32'h0);
    check("reset rdata", rdata, 32'h0);

    rst = 1'b0;
    repeat (10) tick();
    load_chk("cycle after 10 idle", 32'h8000_0010, 32'd10, 1'b0);
    tick();
    check("mmio_hit one cycle", 32'(mmio_hit), 32'h0);

    for (int i = 0; i < 10; i++) begin
      rx_valid = vecs[i].rx_v;
      rx_data  = vecs[i].rx_d;
      tx_ready = vecs[i].tx_r;
      load_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_pop);
    end
    tick();
    check("rx_ready idle", 32'(rx_ready), 32'h0);

    rx_valid = 1'b0;
    tx_ready = 1'b1;
    store(32'h8000_0008, 32'h1234_5641);
    check("tx pulse valid", 32'(tx_valid), 32'h1);
    check("tx pulse data", 32'(tx_data), 32'h41);
    tick();
    check("tx pulse one cycle", 32'(tx_valid), 32'h0);

    tx_ready = 1'b0;
    store(32'h8000_0008, 32'h0000_0042);
`ifdef MMIO_TX_BUF_EN
    check("tx busy buffered valid", 32'(tx_valid), 32'h1);
    check("tx busy buffered data", 32'(tx_data), 32'h42);
`else
    check("tx busy dropped valid", 32'(tx_valid), 32'h0);
    check("tx busy dropped data", 32'(tx_data), 32'h41);
`endif
    load_chk("status tx busy", 32'h8000_0000, 32'h0, 1'b0);
    check("tx hold while busy", 32'(tx_valid), 32'(BUF));
    tx_ready = 1'b1;
    tick();
    check("tx after ready", 32'(tx_valid), 32'h0);
    load_chk("status tx free", 32'h8000_0000, 32'h1, 1'b0);

    addr = 32'h8000_0008; wdata = 32'h99; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    check("we+re tx_valid", 32'(tx_valid), 32'h1);
    check("we+re tx_data", 32'(tx_data), 32'h99);
    check("we+re rdata", rdata, 32'h0);
    check("we+re hit", 32'(mmio_hit), 32'h1);
    tick();

    store(32'h8000_0018, 32'h0);
    load_chk("cycle after clear", 32'h8000_0010, 32'h0, 1'b0);
    load_chk("inst after clear", 32'h8000_0014, 32'h0, 1'b0);
    pat = 12'b1011_0101_1010;
    for (int i = 0; i < 12; i++) begin
      inst_retire = pat[i];
      tick();
    end
    inst_retire = 1'b0;
    load_chk("inst 7 of 12", 32'h8000_0014, 32'd7, 1'b0);
    load_chk("cycle 15", 32'h8000_0010, 32'd15, 1'b0);

    inst_retire = 1'b1;
    store(32'h8000_0018, 32'h0);
    inst_retire = 1'b0;
    load_chk("inst clear beats inc", 32'h8000_0014, 32'h0, 1'b0);
    load_chk("cycle clear beats inc", 32'h8000_0010, 32'h1, 1'b0);

    force dut.u_cycle_cnt.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_cycle_cnt.cnt_q;
    load_chk("cycle max", 32'h8000_0010, 32'hFFFF_FFFF, 1'b0);
    load_chk("cycle wrap", 32'h8000_0010, 32'h0, 1'b0);

    tx_ready = 1'b1;
    store(32'h8000_0008, 32'h55);
    check("pre-reset tx_valid", 32'(tx_valid), 32'h1);
    rst = 1'b1;
    tick();
    check("mid reset tx_valid", 32'(tx_valid), 32'h0);
    check("mid reset tx_data", 32'(tx_data), 32'h0);
    check("mid reset rdata", rdata, 32'h0);
    rst = 1'b0;
    load_chk("inst after reset", 32'h8000_0014, 32'h0, 1'b0);

    check("scoreboard empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
